mem_io_bridge: RTL and testbench
================================

Name: mem_io_bridge

Overview:
Memory-side stage directly downstream of the 5-phase processor. Consumes the processor bus (m_addr, m_rw, m_data) and returns m_q. Decodes the 12-bit address space into on-chip RAM (0x000-0xEFF) and a memory-mapped I/O page (0xF00-0xFFF): LED output register, synchronised switch input, transmit FIFO with valid/ready stream, status register and 32-bit cycle counter.

Parameters:
FIFO_DEPTH, 8, transmit FIFO entries (power of 2, >=2)
CNT_W, 32, cycle counter width (fixed 32, split LO/HI)

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low reset
m_addr  input  12  processor word address
m_rw  input  1  1 = write, 0 = read
m_data  input  16  processor write data
m_q  output  16  read data to processor
ram_addr  output  12  RAM address (combinational from m_addr)
ram_we  output  1  RAM write enable
ram_wdata  output  16  RAM write data (= m_data)
ram_rdata  input  16  RAM synchronous read data, 1-cycle latency
led_out  output  16  LED register
sw_in  input  16  asynchronous switch inputs
tx_valid  output  1  FIFO head valid
tx_ready  input  1  consumer accepts head
tx_data  output  16  FIFO head data

Behaviour:
- Reset (reset=0, async): m_q=0, led_out=0, tx_valid=0, tx_data=0, FIFO empty, overflow=0, counter=0, sync flops=0, m_rw_d=0, hi_snap=0.
- Region: ram_sel = (m_addr < 0xF00). ram_we = m_rw & ram_sel; ram_addr = m_addr; RAM writes every cycle m_rw=1 (repeat is idempotent).
- Read latency: 1 clock for every address. Register ram_sel and m_addr[3:0] at posedge; m_q = registered_ram_sel ? ram_rdata : io_rd_reg, where io_rd_reg is captured at the same edge. m_q must not depend combinationally on the current m_addr.
- I/O map (writes use write-edge rule below unless noted):
  - 0xF00 LED: R/W; write loads led_out on every m_rw=1 cycle.
  - 0xF01 SW: read-only, sw_in through 2-flop synchroniser; writes ignored.
  - 0xF02 TX: write pushes m_data; read returns FIFO count zero-extended.
  - 0xF03 STATUS: read {13'b0, overflow, empty, full}; write clears overflow.
  - 0xF04 CYC_LO: read returns counter[15:0] and loads hi_snap <= counter[31:16] same edge.
  - 0xF05 CYC_HI: read returns hi_snap.
  - 0xF06-0xFFF: read 0, writes ignored.
- Write-edge rule: processor holds m_rw=1 over several clocks. Side-effecting writes (TX push, STATUS clear) act only when m_rw & ~m_rw_d (m_rw_d = m_rw delayed 1 clock).
- FIFO: push on TX write edge; pop when tx_valid & tx_ready. tx_valid = ~empty; tx_data = head (show-ahead). Push when full: data dropped, overflow set (sticky). Push and pop in same cycle when full: pop completes, push accepted, count unchanged. Push when empty: tx_valid rises next clock. Pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
- Overflow: set and clear in same cycle -> set wins.
- Counter: increments every clock, wraps 0xFFFFFFFF -> 0.
- Reset mid-transfer: FIFO contents discarded, tx_valid drops immediately.

Decomposition:
- Package mem_io_pkg: address constants (IO_BASE=12'hF00, A_LED, A_SW, A_TX, A_STATUS, A_CYC_LO, A_CYC_HI), STATUS bit indices.
- Sub-module tx_fifo (synchronous FIFO: push/pop/full/empty/count, show-ahead head). Decode, I/O registers, counter and read mux live in mem_io_bridge.

Test Plan:
- RAM: write 0x1234 to 0x010 with m_rw held 2 clocks, then read 0x010 -> m_q=0x1234 one clock after address; ram_we asserted only during write.
- LED/SW: write 0xA5A5 to 0xF00 -> led_out=0xA5A5; read 0xF00 -> 0xA5A5; sw_in=0x00FF -> read 0xF01 returns 0x00FF no earlier than 3 clocks after change.
- FIFO handshake: tx_ready=0, write 0x0001,0x0002,0x0003 to 0xF02 with m_rw held 2 clocks each -> count=3 (not 6); raise tx_ready -> tx_data 1,2,3 in order, then tx_valid=0.
- Overflow: 9 pushes at FIFO_DEPTH=8 with tx_ready=0 -> STATUS=0x0005 (full, overflow), 9th value absent from output; write 0xF03 -> STATUS=0x0001.
- Counter snapshot: after reset run 0x10005 clocks, read 0xF04 then 0xF05 -> HI=0x0001 even if counter[31:16] changes between reads; LO matches counter at read edge.
- Async reset: assert reset with FIFO holding 3 entries and led_out=0xFFFF -> tx_valid, led_out, m_q zero without a clock edge; unmapped 0xF10 read returns 0.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants for the memory / I/O bridge:
// I/O page address map and STATUS register bit positions.
package mem_io_pkg;

    localparam logic [11:0] IO_BASE  = 12'hF00;
    localparam logic [11:0] A_LED    = 12'hF00;
    localparam logic [11:0] A_SW     = 12'hF01;
    localparam logic [11:0] A_TX     = 12'hF02;
    localparam logic [11:0] A_STATUS = 12'hF03;
    localparam logic [11:0] A_CYC_LO = 12'hF04;
    localparam logic [11:0] A_CYC_HI = 12'hF05;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;

endpackage

// File: rtl/mem_io_bridge_tx_fifo.sv
// Synchronous show-ahead transmit FIFO.
// A push while full is accepted only if a pop frees a slot that same cycle.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [W-1:0]               head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory-side stage: RAM / I/O page decode, I/O registers,
// cycle counter and a uniform 1-cycle read path back to the processor.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] m_addr,
    input  logic        m_rw,
    input  logic [15:0] m_data,
    output logic [15:0] m_q,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic [15:0] led_out,
    input  logic [15:0] sw_in,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] tx_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             r_ram_sel_q;
    logic [15:0]      r_io_rd;
    logic             r_m_rw_d;
    logic [15:0]      r_led;
    logic [15:0]      r_sw_s1;
    logic [15:0]      r_sw_s2;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_hi_snap;
    logic             r_ovf;

    logic             w_ram_sel;
    logic             w_wr_edge;
    logic             w_push;
    logic             w_pop;
    logic             w_clr;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [15:0]      w_io_rd;

    assign w_ram_sel = (m_addr < IO_BASE);
    assign ram_addr  = m_addr;
    assign ram_we    = m_rw & w_ram_sel;
    assign ram_wdata = m_data;

    assign w_wr_edge = m_rw & ~r_m_rw_d;
    assign w_push    = w_wr_edge & (m_addr == A_TX);
    assign w_clr     = w_wr_edge & (m_addr == A_STATUS);
    assign w_pop     = tx_valid & tx_ready;

    assign tx_valid  = ~w_empty;
    assign led_out   = r_led;
    assign m_q       = r_ram_sel_q ? ram_rdata : r_io_rd;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (w_push),
        .wdata (m_data),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .head  (tx_data)
    );

    // I/O read mux; RAM addresses fall to default and are ignored later.
    always_comb begin
        w_io_rd = '0;
        case (m_addr)
            A_LED:    w_io_rd = r_led;
            A_SW:     w_io_rd = r_sw_s2;
            A_TX:     w_io_rd = 16'(w_count);
            A_STATUS: begin
                w_io_rd[ST_OVF]   = r_ovf;
                w_io_rd[ST_EMPTY] = w_empty;
                w_io_rd[ST_FULL]  = w_full;
            end
            A_CYC_LO: w_io_rd = r_cnt[15:0];
            A_CYC_HI: w_io_rd = r_hi_snap;
            default:  w_io_rd = '0;
        endcase
    end

    // Read path, I/O registers, synchroniser, counter and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ram_sel_q <= 1'b0;
            r_io_rd     <= '0;
            r_m_rw_d    <= 1'b0;
            r_led       <= '0;
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_cnt       <= '0;
            r_hi_snap   <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_ram_sel_q <= w_ram_sel;
            r_io_rd     <= w_io_rd;
            r_m_rw_d    <= m_rw;
            r_sw_s1     <= sw_in;
            r_sw_s2     <= r_sw_s1;
            r_cnt       <= r_cnt + 1'b1;
            if (m_rw && (m_addr == A_LED)) begin
                r_led <= m_data;
            end
            if (!m_rw && (m_addr == A_CYC_LO)) begin
                r_hi_snap <= r_cnt[CNT_W-1:16];
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_mem_io_bridge;

    logic        clock;
    logic        reset;
    logic [11:0] m_addr;
    logic        m_rw;
    logic [15:0] m_data;
    logic [15:0] m_q;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] led_out;
    logic [15:0] sw_in;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_data;

    int errors = 0;
    int checks = 0;

    logic [15:0] ram [0:4095];

    mem_io_bridge #(
        .FIFO_DEPTH (8),
        .CNT_W      (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .m_addr    (m_addr),
        .m_rw      (m_rw),
        .m_data    (m_data),
        .m_q       (m_q),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .led_out   (led_out),
        .sw_in     (sw_in),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM with 1-cycle read latency.
    always @(posedge clock) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tx_write(input logic [15:0] v);
        m_addr = 12'hF02;
        m_data = v;
        m_rw   = 1'b1;
        tick();
        tick();
        m_rw   = 1'b0;
        tick();
    endtask

    initial begin
        reset    = 1'b0;
        m_addr   = 12'h000;
        m_rw     = 1'b0;
        m_data   = 16'h0000;
        sw_in    = 16'h0000;
        tx_ready = 1'b0;
        #3;
        chk("rst_m_q", m_q, 16'h0000);
        chk("rst_led", led_out, 16'h0000);
        chk("rst_txv", {15'b0, tx_valid}, 16'h0000);
        chk("rst_txd", tx_data, 16'h0000);
        tick();
        tick();
        reset = 1'b1;

        // RAM write held two clocks, then read back
        m_addr = 12'h010;
        m_data = 16'h1234;
        m_rw   = 1'b1;
        #1;
        chk("ram_we_wr", {15'b0, ram_we}, 16'h0001);
        chk("ram_addr", {4'b0, ram_addr}, 16'h0010);
        tick();
        tick();
        m_rw = 1'b0;
        #1;
        chk("ram_we_rd", {15'b0, ram_we}, 16'h0000);
        tick();
        chk("ram_rd", m_q, 16'h1234);

        // top RAM word boundary
        m_addr = 12'hEFF;
        m_data = 16'hBEEF;
        m_rw   = 1'b1;
        #1;
        chk("ram_we_eff", {15'b0, ram_we}, 16'h0001);
        tick();
        m_rw = 1'b0;
        tick();
        chk("ram_rd_eff", m_q, 16'hBEEF);

        // LED write/read; I/O page must not strobe RAM
        m_addr = 12'hF00;
        m_data = 16'hA5A5;
        m_rw   = 1'b1;
        #1;
        chk("ram_we_io", {15'b0, ram_we}, 16'h0000);
        tick();
        chk("led_out", led_out, 16'hA5A5);
        m_rw = 1'b0;
        tick();
        chk("led_rd", m_q, 16'hA5A5);

        // switch synchroniser latency
        m_addr = 12'hF01;
        sw_in  = 16'h00FF;
        tick();
        chk("sw_1clk", m_q, 16'h0000);
        tick();
        chk("sw_2clk", m_q, 16'h0000);
        tick();
        chk("sw_3clk", m_q, 16'h00FF);

        // FIFO: held writes push once each
        tx_write(16'h0001);
        tx_write(16'h0002);
        tx_write(16'h0003);
        m_addr = 12'hF02;
        tick();
        chk("tx_count", m_q, 16'h0003);
        chk("tx_valid", {15'b0, tx_valid}, 16'h0001);
        m_addr   = 12'h000;
        tx_ready = 1'b1;
        #1;
        chk("tx_d1", tx_data, 16'h0001);
        tick();
        chk("tx_d2", tx_data, 16'h0002);
        tick();
        chk("tx_d3", tx_data, 16'h0003);
        tick();
        chk("tx_drained", {15'b0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;

        // overflow: ninth push dropped, sticky flag
        for (int i = 0; i < 9; i++) begin
            m_addr = 12'hF02;
            m_data = 16'h0010 + 16'(i);
            m_rw   = 1'b1;
            tick();
            m_rw   = 1'b0;
            tick();
        end
        m_addr = 12'hF03;
        tick();
        chk("status_ovf", m_q, 16'h0005);
        m_rw = 1'b1;
        tick();
        m_rw = 1'b0;
        tick();
        chk("status_clr", m_q, 16'h0001);
        m_addr   = 12'h000;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("ovf_drain", tx_data, 16'h0010 + 16'(i));
            tick();
        end
        chk("ovf_9th_gone", {15'b0, tx_valid}, 16'h0000);
        tx_ready = 1'b0;

        // async reset with FIFO occupied and LED lit
        tx_write(16'h0021);
        tx_write(16'h0022);
        tx_write(16'h0023);
        m_addr = 12'hF00;
        m_data = 16'hFFFF;
        m_rw   = 1'b1;
        tick();
        m_rw = 1'b0;
        tick();
        chk("pre_rst_mq", m_q, 16'hFFFF);
        chk("pre_rst_txv", {15'b0, tx_valid}, 16'h0001);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_txv", {15'b0, tx_valid}, 16'h0000);
        chk("arst_led", led_out, 16'h0000);
        chk("arst_mq", m_q, 16'h0000);
        chk("arst_txd", tx_data, 16'h0000);
        m_addr = 12'hF05;
        #2;
        reset = 1'b1;

        // cycle counter with LO/HI snapshot across a carry
        repeat (16'hFFFF) tick();
        m_addr = 12'hF04;
        tick();
        chk("cyc_lo_a", m_q, 16'hFFFF);
        m_addr = 12'hF05;
        tick();
        chk("cyc_hi_a", m_q, 16'h0000);
        repeat (4) tick();
        m_addr = 12'hF04;
        tick();
        chk("cyc_lo_b", m_q, 16'h0005);
        m_addr = 12'hF05;
        tick();
        chk("cyc_hi_b", m_q, 16'h0001);

        // unmapped I/O reads as zero
        m_addr = 12'hF10;
        tick();
        chk("unmapped", m_q, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
